// File: rtl/fill_sequencer.sv
// Tablet-bottling run controller: feeder gate, per-bottle pill count,
// bottle-change handshake with the conveyor and batch completion.
module fill_sequencer #(
   parameter int unsigned CHANGE_TIMEOUT = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       cfg_valid,
   input  logic [3:0] cfg_pills_t,
   input  logic [3:0] cfg_pills_u,
   input  logic [3:0] cfg_bottles_t,
   input  logic [3:0] cfg_bottles_u,
   input  logic       pill_pulse,
   input  logic       change_ack,
   output logic       gate_open,
   output logic       change_req,
   output logic [3:0] pill_t,
   output logic [3:0] pill_u,
   output logic [3:0] bottle_t,
   output logic [3:0] bottle_u,
   output logic [3:0] total_h,
   output logic [3:0] total_t,
   output logic [3:0] total_u,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic       cfg_err
);

   localparam int unsigned TW =
      (CHANGE_TIMEOUT > 1) ? $clog2(CHANGE_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(CHANGE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHANGE,
      S_DONE,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    tgt_p_q, tgt_p_d;
   logic [7:0]    tgt_b_q, tgt_b_d;
   logic [7:0]    pill_q, pill_d;
   logic [7:0]    bot_q, bot_d;
   logic [11:0]   tot_q, tot_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          cfg_ok_q, cfg_ok_d;
   logic          cfg_err_q, cfg_err_d;
   logic          cfg_bad;
   logic [7:0]    pill_inc, bot_inc;
   logic [11:0]   tot_inc;

   function automatic logic [3:0] dnext(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [7:0] inc2(input logic [7:0] v);
      logic cu;
      cu = (v[3:0] == 4'd9);
      return {cu ? dnext(v[7:4]) : v[7:4], dnext(v[3:0])};
   endfunction

   // Three-digit count wraps 999 -> 000 through the hundreds digit
   function automatic logic [11:0] inc3(input logic [11:0] v);
      logic cu, ct;
      cu = (v[3:0] == 4'd9);
      ct = cu && (v[7:4] == 4'd9);
      return {ct ? dnext(v[11:8]) : v[11:8],
              cu ? dnext(v[7:4])  : v[7:4],
              dnext(v[3:0])};
   endfunction

   assign pill_inc = inc2(pill_q);
   assign bot_inc  = inc2(bot_q);
   assign tot_inc  = inc3(tot_q);

   assign cfg_bad = (cfg_pills_t   > 4'd9)
                 || (cfg_pills_u   > 4'd9)
                 || (cfg_bottles_t > 4'd9)
                 || (cfg_bottles_u > 4'd9)
                 || ({cfg_pills_t, cfg_pills_u} == 8'h00)
                 || ({cfg_bottles_t, cfg_bottles_u} == 8'h00);

   always_comb begin
      state_d    = state_q;
      tgt_p_d    = tgt_p_q;
      tgt_b_d    = tgt_b_q;
      pill_d     = pill_q;
      bot_d      = bot_q;
      tot_d      = tot_q;
      tmo_d      = '0;
      cfg_ok_d   = cfg_ok_q;
      cfg_err_d  = cfg_err_q;
      gate_open  = 1'b0;
      change_req = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               if (cfg_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  tgt_p_d   = {cfg_pills_t, cfg_pills_u};
                  tgt_b_d   = {cfg_bottles_t, cfg_bottles_u};
                  cfg_ok_d  = 1'b1;
                  cfg_err_d = 1'b0;
               end
            end else if (start && cfg_ok_q) begin
               state_d = S_FILL;
               pill_d  = '0;
               bot_d   = '0;
               tot_d   = '0;
            end
         end
         S_FILL: begin
            gate_open = start;
            if (start && pill_pulse) begin
               pill_d = pill_inc;
               tot_d  = tot_inc;
               if (pill_inc == tgt_p_q) state_d = S_CHANGE;
            end
         end
         S_CHANGE: begin
            change_req = 1'b1;
            // An ack on the final timeout cycle still completes the change
            if (change_ack) begin
               bot_d   = bot_inc;
               pill_d  = '0;
               state_d = (bot_inc == tgt_b_q) ? S_DONE : S_FILL;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         tgt_p_q   <= '0;
         tgt_b_q   <= '0;
         pill_q    <= '0;
         bot_q     <= '0;
         tot_q     <= '0;
         tmo_q     <= '0;
         cfg_ok_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgt_p_q   <= tgt_p_d;
         tgt_b_q   <= tgt_b_d;
         pill_q    <= pill_d;
         bot_q     <= bot_d;
         tot_q     <= tot_d;
         tmo_q     <= tmo_d;
         cfg_ok_q  <= cfg_ok_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign pill_t   = pill_q[7:4];
   assign pill_u   = pill_q[3:0];
   assign bottle_t = bot_q[7:4];
   assign bottle_u = bot_q[3:0];
   assign total_h  = tot_q[11:8];
   assign total_t  = tot_q[7:4];
   assign total_u  = tot_q[3:0];
   assign busy     = (state_q == S_FILL) || (state_q == S_CHANGE);
   assign done     = (state_q == S_DONE);
   assign fault    = (state_q == S_FAULT);
   assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Random-stimulus bench for fill_sequencer: a pill/bottle count model
// feeds event and count queues that a negedge monitor drains.
module tb_fill_sequencer;

   localparam int TMO      = 50;
   localparam int EV_CHG   = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_FAULT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_pills_t = '0;
   logic [3:0] cfg_pills_u = '0;
   logic [3:0] cfg_bottles_t = '0;
   logic [3:0] cfg_bottles_u = '0;
   logic       pill_pulse = 1'b0;
   logic       change_ack = 1'b0;
   logic       gate_open, change_req;
   logic [3:0] pill_t, pill_u, bottle_t, bottle_u;
   logic [3:0] total_h, total_t, total_u;
   logic       busy, done, fault, cfg_err;

   fill_sequencer #(.CHANGE_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(rst_n), .start(start),
      .cfg_valid(cfg_valid),
      .cfg_pills_t(cfg_pills_t), .cfg_pills_u(cfg_pills_u),
      .cfg_bottles_t(cfg_bottles_t),
      .cfg_bottles_u(cfg_bottles_u),
      .pill_pulse(pill_pulse), .change_ack(change_ack),
      .gate_open(gate_open), .change_req(change_req),
      .pill_t(pill_t), .pill_u(pill_u),
      .bottle_t(bottle_t), .bottle_u(bottle_u),
      .total_h(total_h), .total_t(total_t), .total_u(total_u),
      .busy(busy), .done(done), .fault(fault), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wire [7:0]  pill_v  = {pill_t, pill_u};
   wire [7:0]  bot_v   = {bottle_t, bottle_u};
   wire [11:0] tot_v   = {total_h, total_t, total_u};
   wire [27:0] cnt_all = {pill_v, bot_v, tot_v};
   wire [5:0]  flg_all = {gate_open, change_req, busy,
                          done, fault, cfg_err};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] enc2(int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic logic [11:0] enc3(int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   typedef struct {
      int          kind;
      int unsigned at;
      int          pill;
      int          bot;
      int          tot;
   } ev_t;
   typedef struct {
      int pill;
      int tot;
   } cnt_t;

   ev_t  evq[$];
   cnt_t cntq[$];

   // Reference model: targets and counts as plain integers
   int cur_p = 0, cur_b = 0;
   int m_pill = 0, m_bot = 0, m_tot = 0;

   task automatic pop_ev(int kind);
      ev_t e;
      if (evq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ev_unexpected: kind %0d, none expected (cycle %0d)",
                  kind, cyc);
         return;
      end
      e = evq.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.at);
      chk("ev_pill", pill_v, enc2(e.pill));
      chk("ev_bottle", bot_v, enc2(e.bot));
      chk("ev_total", tot_v, enc3(e.tot));
      if (kind == EV_CHG) chk("ev_chg_gate", gate_open, 0);
   endtask

   task automatic pop_cnt();
      cnt_t c;
      if (cntq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL cnt_unexpected: pill %0h total %0h (cycle %0d)",
                  pill_v, tot_v, cyc);
         return;
      end
      c = cntq.pop_front();
      chk("cnt_pill", pill_v, enc2(c.pill));
      chk("cnt_total", tot_v, enc3(c.tot));
   endtask

   logic        prev_req = 1'b0, prev_done = 1'b0, prev_fault = 1'b0;
   logic [19:0] prev_cnt = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req   <= 1'b0;
         prev_done  <= 1'b0;
         prev_fault <= 1'b0;
         prev_cnt   <= '0;
      end else begin
         if (change_req && !prev_req) pop_ev(EV_CHG);
         if (done && !prev_done) pop_ev(EV_DONE);
         if (fault && !prev_fault) pop_ev(EV_FAULT);
         if ({pill_v, tot_v} !== prev_cnt) pop_cnt();
         prev_req   <= change_req;
         prev_done  <= done;
         prev_fault <= fault;
         prev_cnt   <= {pill_v, tot_v};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cfg_valid  = 1'b0;
      change_ack = 1'b0;
      pill_pulse = 1'b0;
   endtask

   task automatic cfg_load(int pt, int pu, int bt, int bu);
      bit bad;
      bad = (pt > 9) || (pu > 9) || (bt > 9) || (bu > 9)
         || (pt * 10 + pu == 0) || (bt * 10 + bu == 0);
      step();
      start         = 1'b0;
      cfg_valid     = 1'b1;
      cfg_pills_t   = 4'(pt);
      cfg_pills_u   = 4'(pu);
      cfg_bottles_t = 4'(bt);
      cfg_bottles_u = 4'(bu);
      step();
      chk("cfg_err", cfg_err, bad);
      if (!bad) begin
         cur_p = pt * 10 + pu;
         cur_b = bt * 10 + bu;
      end
   endtask

   task automatic begin_run();
      step();
      start = 1'b1;
      if (m_pill != 0 || m_tot != 0) cntq.push_back('{0, 0});
      m_pill = 0;
      m_bot  = 0;
      m_tot  = 0;
      step();
      chk("run_busy", busy, 1);
      chk("run_gate", gate_open, 1);
      chk("run_bottle", bot_v, 0);
   endtask

   task automatic pulse(bit s, bit p);
      step();
      start      = s;
      pill_pulse = p;
      if (s && p) begin
         m_pill++;
         m_tot = (m_tot + 1) % 1000;
         cntq.push_back('{m_pill, m_tot});
         if (m_pill == cur_p)
            evq.push_back('{EV_CHG, cyc + 1, m_pill, m_bot, m_tot});
      end
   endtask

   task automatic fill_bottle(int pause);
      while (m_pill < cur_p)
         pulse(int'($urandom_range(99)) >= pause,
               1'($urandom_range(1)));
   endtask

   task automatic change(int d);
      step();
      pill_pulse = 1'($urandom_range(1));
      chk("req_on", change_req, 1);
      chk("gate_off", gate_open, 0);
      repeat (d) begin
         step();
         pill_pulse = 1'($urandom_range(1));
      end
      change_ack = 1'b1;
      m_bot++;
      m_pill = 0;
      cntq.push_back('{0, m_tot});
      if (m_bot == cur_b)
         evq.push_back('{EV_DONE, cyc + 1, 0, m_bot, m_tot});
      step();
      chk("req_drop", change_req, 0);
      chk("ack_busy", busy, m_bot != cur_b);
   endtask

   task automatic finish_run();
      chk("done", done, 1);
      chk("done_gate", gate_open, 0);
      step();
      start = 1'b0;
      step();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("held_pill", pill_v, 0);
      chk("held_bottle", bot_v, enc2(m_bot));
      chk("held_total", tot_v, enc3(m_tot));
   endtask

   task automatic run_batch(int pause, int ack_max);
      for (int b = 0; b < cur_b; b++) begin
         fill_bottle(pause);
         change(int'($urandom_range(ack_max)));
      end
      finish_run();
   endtask

   task automatic apply_reset();
      chk("evq_empty", evq.size(), 0);
      chk("cntq_empty", cntq.size(), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_counts", cnt_all, 0);
      chk("rst_flags", flg_all, 0);
      m_pill = 0;
      m_bot  = 0;
      m_tot  = 0;
      cur_p  = 0;
      cur_b  = 0;
      start  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p, b;
      #3;
      chk("por_counts", cnt_all, 0);
      chk("por_flags", flg_all, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Normal batch 03/02, cfg strobes in FILL must be ignored
      cfg_load(0, 3, 0, 2);
      begin_run();
      pulse(1, 1);
      cfg_valid   = 1'b1;
      cfg_pills_u = 4'hA;
      pulse(1, 0);
      cfg_valid     = 1'b1;
      cfg_pills_t   = 4'd9;
      cfg_pills_u   = 4'd9;
      cfg_bottles_t = 4'd9;
      cfg_bottles_u = 4'd9;
      fill_bottle(0);
      change(2);
      fill_bottle(0);
      change(2);
      chk("a_total", tot_v, 12'h006);
      chk("a_bottle", bot_v, 8'h02);
      chk("a_cfg_err", cfg_err, 0);
      finish_run();

      // Bad configs leave 03/02 in place
      cfg_load(0, 10, 0, 2);
      cfg_load(0, 0, 0, 5);
      cfg_load(0, 3, 15, 1);
      begin_run();
      run_batch(20, 3);

      // Pause: pulses with start low are not counted
      cfg_load(0, 5, 0, 1);
      begin_run();
      pulse(1, 1);
      pulse(1, 1);
      repeat (3) pulse(0, 1);
      chk("pause_pill", pill_v, 8'h02);
      chk("pause_gate", gate_open, 0);
      chk("pause_busy", busy, 1);
      repeat (3) pulse(1, 1);
      change(1);
      finish_run();

      // BCD carries, immediate acks
      cfg_load(1, 2, 0, 9);
      begin_run();
      run_batch(0, 0);
      chk("bcd_total", tot_v, 12'h108);
      chk("bcd_bottle", bot_v, 8'h09);

      // Randomised batches
      for (int r = 0; r < 6; r++) begin
         p = int'($urandom_range(20, 1));
         b = int'($urandom_range(6, 1));
         cfg_load(p / 10, p % 10, b / 10, b % 10);
         begin_run();
         run_batch(int'($urandom_range(40)), 4);
      end

      // Full digits and total wrap past 999
      cfg_load(9, 9, 1, 1);
      begin_run();
      run_batch(10, 1);
      chk("wrap_total", tot_v, 12'h089);

      // Ack on the last timeout cycle wins, then a real timeout
      cfg_load(0, 1, 0, 2);
      begin_run();
      pulse(1, 1);
      step();
      repeat (TMO - 1) step();
      chk("tmo_edge_req", change_req, 1);
      chk("tmo_edge_fault", fault, 0);
      change_ack = 1'b1;
      m_bot++;
      m_pill = 0;
      cntq.push_back('{0, m_tot});
      step();
      chk("tmo_ack_fault", fault, 0);
      chk("tmo_ack_busy", busy, 1);
      chk("tmo_ack_req", change_req, 0);
      pulse(1, 1);
      evq.push_back('{EV_FAULT, cyc + 1 + TMO, m_pill, m_bot, m_tot});
      step();
      repeat (TMO - 1) step();
      chk("tmo_pre_fault", fault, 0);
      step();
      chk("tmo_fault", fault, 1);
      chk("tmo_flags", flg_all, 6'b000010);
      repeat (4) begin
         step();
         pill_pulse = 1'b1;
         change_ack = 1'b1;
      end
      step();
      chk("fault_stuck", fault, 1);
      chk("fault_pill", pill_v, 8'h01);
      chk("fault_bottle", bot_v, 8'h01);
      apply_reset();

      // Reset during CHANGE, then start alone must not run
      cfg_load(0, 2, 0, 3);
      begin_run();
      fill_bottle(0);
      step();
      step();
      chk("pre_rst_req", change_req, 1);
      apply_reset();
      step();
      start = 1'b1;
      repeat (5) step();
      chk("noconf_busy", busy, 0);
      chk("noconf_gate", gate_open, 0);
      cfg_load(0, 4, 0, 2);
      begin_run();
      run_batch(10, 2);

      repeat (3) step();
      chk("end_evq", evq.size(), 0);
      chk("end_cntq", cntq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
